dff_bank_arbiter: RTL and testbench

//  Shares one WIDTH-bit enabled D register among N_REQ requesters; round-robin write arbitration.

---
 rtl/dff_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit register written by N_REQ requesters under round-robin arbitration with optional burst lock.
// A grant is issued one edge after req is seen; the write and its ack land on the following edge.
module dff_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset_sync_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic                   clr,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       Q,
    output logic                   busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt, ack_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [CW-1:0]    burst_cnt, burst_cnt_nxt;

    logic [PW-1:0]    winner;
    logic             found;
    logic [PW-1:0]    owner_after;
    logic [CW:0]      burst_inc;
    int               idx;

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign owner_after = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign burst_inc   = {1'b0, burst_cnt} + (CW+1)'(1);

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        ack_nxt       = '0;
        q_nxt         = Q;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;

        if (clr) begin
            // Clear aborts any pending write but keeps fairness position.
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            q_nxt         = '0;
            burst_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_nxt = '0;
                    if (found) begin
                        gnt_nxt[winner] = 1'b1;
                        owner_nxt       = winner;
                        burst_cnt_nxt   = '0;
                        state_nxt       = GRANT;
                    end
                end
                GRANT, LOCKED: begin
                    if (req[owner]) begin
                        q_nxt          = wdata[owner*WIDTH +: WIDTH];
                        ack_nxt[owner] = 1'b1;
                        burst_cnt_nxt  = burst_inc[CW-1:0];
                        if (lock[owner] && (burst_inc < (CW+1)'(MAX_BURST))) begin
                            state_nxt = LOCKED;
                        end else begin
                            gnt_nxt    = '0;
                            rr_ptr_nxt = owner_after;
                            state_nxt  = IDLE;
                        end
                    end else begin
                        gnt_nxt    = '0;
                        rr_ptr_nxt = owner_after;
                        state_nxt  = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            state     <= IDLE;
            gnt       <= '0;
            ack       <= '0;
            Q         <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            Q         <= q_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with 4 requesters, 8-bit data, MAX_BURST=4.
module tb_dff_bank_arbiter;
    logic        clk = 1'b0;
    logic        reset_sync_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  Q;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset_sync_n (reset_sync_n),
        .req          (req),
        .lock         (lock),
        .wdata        (wdata),
        .clr          (clr),
        .gnt          (gnt),
        .ack          (ack),
        .Q            (Q),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_sync_n = 1'b0;
        req = '0; lock = '0; clr = 1'b0;
        tick();
        reset_sync_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_sync_n = 1'b0;
        req = 4'b1111; lock = '0; clr = 1'b0; wdata = 32'h13121110;
        tick();
        tick();
        vectors++; if (Q !== 8'h00)    begin miscompares++; $display("FAIL reset_q: got %h want 00", Q); end
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", ack); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_sync_n = 1'b1;
        tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
        vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL reset_first_busy: got %b want 1", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        logic [7:0] exp_q;
        do_reset();
        req = 4'b1111; lock = '0; wdata = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            exp_q  = 8'h10 + 8'(k % 4);
            tick();
            vectors++; if (gnt !== exp_oh)  begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_oh); end
            vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL rr_ack_idle[%0d]: got %b want 0000", k, ack); end
            tick();
            vectors++; if (ack !== exp_oh)  begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ack, exp_oh); end
            vectors++; if (Q !== exp_q)     begin miscompares++; $display("FAIL rr_q[%0d]: got %h want %h", k, Q, exp_q); end
            vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_gnt_rel[%0d]: got %b want 0000", k, gnt); end
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b0110; lock = 4'b0010; wdata = 32'h00002000;
        tick();
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL lock_first_gnt: got %b want 0010", gnt); end
        for (int j = 0; j < 4; j++) begin
            wdata[15:8] = 8'h20 + 8'(j);
            tick();
            exp_gnt = (j < 3) ? 4'b0010 : 4'b0000;
            vectors++; if (ack !== 4'b0010)    begin miscompares++; $display("FAIL lock_ack[%0d]: got %b want 0010", j, ack); end
            vectors++; if (Q !== 8'h20 + 8'(j)) begin miscompares++; $display("FAIL lock_q[%0d]: got %h want %h", j, Q, 8'h20 + 8'(j)); end
            vectors++; if (gnt !== exp_gnt)    begin miscompares++; $display("FAIL lock_gnt[%0d]: got %b want %b", j, gnt, exp_gnt); end
        end
        tick();
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL lock_next_gnt: got %b want 0100", gnt); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL lock_next_ack: got %b want 0000", ack); end
    endtask

    task automatic test_clr();
        do_reset();
        req = 4'b0001; lock = '0; wdata = 32'h000000AA;
        tick();
        tick();
        vectors++; if (Q !== 8'hAA) begin miscompares++; $display("FAIL clr_setup_q: got %h want aa", Q); end
        tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL clr_setup_gnt: got %b want 0001", gnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++; if (Q !== 8'h00)     begin miscompares++; $display("FAIL clr_q: got %h want 00", Q); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL clr_ack: got %b want 0000", ack); end
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL clr_gnt: got %b want 0000", gnt); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL clr_busy: got %b want 0", busy); end
        tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL clr_regrant: got %b want 0001", gnt); end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0011; lock = '0; wdata = 32'h00006655;
        tick();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wd_gnt: got %b want 0001", gnt); end
        req = 4'b0010;
        tick();
        vectors++; if (Q !== 8'h00)     begin miscompares++; $display("FAIL wd_q: got %h want 00", Q); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL wd_ack: got %b want 0000", ack); end
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL wd_gnt_rel: got %b want 0000", gnt); end
        tick();
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL wd_next_gnt: got %b want 0010", gnt); end
        tick();
        vectors++; if (Q !== 8'h66)     begin miscompares++; $display("FAIL wd_next_q: got %h want 66", Q); end
    endtask

    task automatic test_reset_locked();
        do_reset();
        // An unlocked write by requester 1 moves the pointer to 2 before the burst.
        req = 4'b0010; lock = '0; wdata = 32'h00332211;
        tick();
        tick();
        req = 4'b0100; lock = 4'b0100;
        tick();
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL rl_gnt: got %b want 0100", gnt); end
        tick();
        vectors++; if (ack !== 4'b0100) begin miscompares++; $display("FAIL rl_ack: got %b want 0100", ack); end
        vectors++; if (Q !== 8'h33)     begin miscompares++; $display("FAIL rl_q: got %h want 33", Q); end
        reset_sync_n = 1'b0;
        tick();
        vectors++; if ({gnt, ack, Q, busy} !== 17'd0) begin miscompares++; $display("FAIL rl_reset_outs: got gnt=%b ack=%b q=%h busy=%b want all zero", gnt, ack, Q, busy); end
        reset_sync_n = 1'b1;
        req = 4'b0110; lock = '0;
        tick();
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rl_after_gnt: got %b want 0010", gnt); end
    endtask

    initial begin
        reset_sync_n = 1'b0;
        req = '0; lock = '0; wdata = '0; clr = 1'b0;
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_clr();
        test_withdraw();
        test_reset_locked();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
